// File: rtl/icache_refill_ctrl_pkg.sv
// Shared types for the instruction-cache refill controller: burst descriptor,
// response FIFO entry, tag-array entry and the refill state encoding.
package icache_refill_ctrl_pkg;

    localparam int ICACHE_LINE_BEATS = 8;
    localparam int ICACHE_TAG_W      = 51;

    typedef enum logic [2:0] {
        FLUSH,
        IDLE,
        REQ,
        FILL,
        DONE
    } refill_state_t;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_t;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        burst_t      burst;
    } imem_req_t;

    typedef struct packed {
        logic        error;
        logic        last;
        logic [63:0] data;
    } fifo_entry_t;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
    } cache_tag_t;

endpackage

// File: rtl/icache_refill_ctrl.sv
// I-cache line refill and invalidate-all sequencer. Optional critical-word-first
// refill (WRAP burst, early response) is enabled by ICACHE_CRIT_WORD_FIRST_EN.
module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
#(
    parameter int LINE_BEATS = ICACHE_LINE_BEATS,
    parameter int INDEX_W    = 7,
    parameter int TAG_W      = 64 - INDEX_W - 6
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          miss_valid,
    output logic                          miss_ready,
    input  logic [63:0]                   miss_addr,
    input  logic                          flush_req,
    output logic                          flush_done,
    output logic                          mem_req_valid,
    input  logic                          mem_req_ready,
    output imem_req_t                     mem_req,
    input  logic                          fifo_valid,
    output logic                          fifo_ready,
    input  fifo_entry_t                   fifo_entry,
    output logic                          data_we,
    output logic [INDEX_W-1:0]            data_index,
    output logic [$clog2(LINE_BEATS)-1:0] data_beat,
    output logic [63:0]                   data_wdata,
    output logic                          tag_we,
    output logic [INDEX_W-1:0]            tag_index,
    output cache_tag_t                    tag_wdata,
    output logic                          resp_valid,
    output logic [63:0]                   resp_data,
    output logic                          resp_error,
    output logic                          fill_done,
    output logic                          busy
);

    localparam int BEAT_W = $clog2(LINE_BEATS);
    localparam int OFF_W  = BEAT_W + 3;

    refill_state_t        state_q, state_d;
    logic [INDEX_W:0]     flush_cnt_q, flush_cnt_d;
    logic [63:0]          addr_q, addr_d;
    logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [BEAT_W-1:0]    pop_cnt_q, pop_cnt_d;
    logic                 err_acc_q, err_acc_d;
    logic                 err_now;

    logic                 flush_done_q, flush_done_d;
    logic                 data_we_q, data_we_d;
    logic [INDEX_W-1:0]   data_index_q, data_index_d;
    logic [BEAT_W-1:0]    data_beat_q, data_beat_d;
    logic [63:0]          data_wdata_q, data_wdata_d;
    logic                 tag_we_q, tag_we_d;
    logic [INDEX_W-1:0]   tag_index_q, tag_index_d;
    cache_tag_t           tag_wdata_q, tag_wdata_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [63:0]          resp_data_q, resp_data_d;
    logic                 resp_error_q, resp_error_d;
    logic                 fill_done_q, fill_done_d;
    logic                 busy_q, busy_d;

    logic [BEAT_W-1:0]    crit_beat;
    assign crit_beat = addr_q[3 +: BEAT_W];

    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        addr_d        = addr_q;
        beat_cnt_d    = beat_cnt_q;
        pop_cnt_d     = pop_cnt_q;
        err_acc_d     = err_acc_q;
        err_now       = err_acc_q;
        flush_done_d  = 1'b0;
        data_we_d     = 1'b0;
        data_index_d  = data_index_q;
        data_beat_d   = data_beat_q;
        data_wdata_d  = data_wdata_q;
        tag_we_d      = 1'b0;
        tag_index_d   = tag_index_q;
        tag_wdata_d   = tag_wdata_q;
        resp_valid_d  = 1'b0;
        resp_data_d   = resp_data_q;
        resp_error_d  = 1'b0;
        fill_done_d   = 1'b0;
        miss_ready    = 1'b0;
        mem_req_valid = 1'b0;
        fifo_ready    = 1'b0;
        mem_req       = '0;

        case (state_q)
            FLUSH: begin
                // The extra top bit of flush_cnt marks the walk as finished.
                if (flush_cnt_q[INDEX_W]) begin
                    flush_done_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    tag_we_d    = 1'b1;
                    tag_index_d = flush_cnt_q[INDEX_W-1:0];
                    tag_wdata_d = '0;
                    flush_cnt_d = flush_cnt_q + (INDEX_W+1)'(1);
                end
            end
            IDLE: begin
                if (flush_req) begin
                    state_d     = FLUSH;
                    flush_cnt_d = '0;
                end else begin
                    miss_ready = 1'b1;
                    if (miss_valid) begin
                        addr_d    = miss_addr;
`ifdef ICACHE_CRIT_WORD_FIRST_EN
                        beat_cnt_d = miss_addr[3 +: BEAT_W];
`else
                        beat_cnt_d = '0;
`endif
                        pop_cnt_d = '0;
                        err_acc_d = 1'b0;
                        state_d   = REQ;
                    end
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                mem_req.len   = 8'(LINE_BEATS - 1);
                mem_req.size  = 3'b011;
`ifdef ICACHE_CRIT_WORD_FIRST_EN
                mem_req.addr  = addr_q & ~64'h7;
                mem_req.burst = WRAP;
`else
                mem_req.addr  = addr_q & ~64'((64'd1 << OFF_W) - 64'd1);
                mem_req.burst = INCR;
`endif
                if (mem_req_ready) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                fifo_ready = 1'b1;
                if (fifo_valid) begin
                    data_we_d    = 1'b1;
                    data_index_d = addr_q[OFF_W +: INDEX_W];
                    data_beat_d  = beat_cnt_q;
                    data_wdata_d = fifo_entry.data;
                    beat_cnt_d   = beat_cnt_q + BEAT_W'(1);
                    pop_cnt_d    = pop_cnt_q + BEAT_W'(1);
                    if (beat_cnt_q == crit_beat) begin
                        resp_data_d = fifo_entry.data;
                    end
                    // A short burst leaves part of the line stale, so it poisons the tag.
                    err_now   = err_acc_q | fifo_entry.error |
                                (fifo_entry.last && (pop_cnt_q != BEAT_W'(LINE_BEATS - 1)));
                    err_acc_d = err_now;
`ifdef ICACHE_CRIT_WORD_FIRST_EN
                    if (pop_cnt_q == '0) begin
                        resp_valid_d = 1'b1;
                        resp_error_d = fifo_entry.error;
                    end
`endif
                    if (fifo_entry.last) begin
                        state_d         = DONE;
                        tag_we_d        = 1'b1;
                        tag_index_d     = addr_q[OFF_W +: INDEX_W];
                        tag_wdata_d.valid = ~err_now;
                        tag_wdata_d.tag = ICACHE_TAG_W'(addr_q[63 -: TAG_W]);
                        fill_done_d     = 1'b1;
`ifndef ICACHE_CRIT_WORD_FIRST_EN
                        resp_valid_d    = 1'b1;
                        resp_error_d    = err_now;
`endif
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = FLUSH;
                flush_cnt_d = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= FLUSH;
            flush_cnt_q  <= '0;
            beat_cnt_q   <= '0;
            pop_cnt_q    <= '0;
            err_acc_q    <= 1'b0;
            flush_done_q <= 1'b0;
            data_we_q    <= 1'b0;
            data_index_q <= '0;
            data_beat_q  <= '0;
            data_wdata_q <= '0;
            tag_we_q     <= 1'b0;
            tag_index_q  <= '0;
            tag_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_error_q <= 1'b0;
            fill_done_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
            pop_cnt_q    <= pop_cnt_d;
            err_acc_q    <= err_acc_d;
            flush_done_q <= flush_done_d;
            data_we_q    <= data_we_d;
            data_index_q <= data_index_d;
            data_beat_q  <= data_beat_d;
            data_wdata_q <= data_wdata_d;
            tag_we_q     <= tag_we_d;
            tag_index_q  <= tag_index_d;
            tag_wdata_q  <= tag_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_error_q <= resp_error_d;
            fill_done_q  <= fill_done_d;
            busy_q       <= busy_d;
        end
    end

    // The miss address is only consumed while a refill is in flight.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
    end

    assign flush_done = flush_done_q;
    assign data_we    = data_we_q;
    assign data_index = data_index_q;
    assign data_beat  = data_beat_q;
    assign data_wdata = data_wdata_q;
    assign tag_we     = tag_we_q;
    assign tag_index  = tag_index_q;
    assign tag_wdata  = tag_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_error = resp_error_q;
    assign fill_done  = fill_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: reset walk, clean/errored/short refills,
// flush priority over a miss, and reset in the middle of a fill.
module tb_icache_refill_ctrl;
    import icache_refill_ctrl_pkg::*;

`ifdef ICACHE_CRIT_WORD_FIRST_EN
    localparam bit CRIT = 1'b1;
`else
    localparam bit CRIT = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        miss_valid;
    logic        miss_ready;
    logic [63:0] miss_addr;
    logic        flush_req;
    logic        flush_done;
    logic        mem_req_valid;
    logic        mem_req_ready;
    imem_req_t   mem_req;
    logic        fifo_valid;
    logic        fifo_ready;
    fifo_entry_t fifo_entry;
    logic        data_we;
    logic [6:0]  data_index;
    logic [2:0]  data_beat;
    logic [63:0] data_wdata;
    logic        tag_we;
    logic [6:0]  tag_index;
    cache_tag_t  tag_wdata;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic        resp_error;
    logic        fill_done;
    logic        busy;

    int checks = 0;
    int errors = 0;

    icache_refill_ctrl dut (
        .clk           (clk),
        .resetn        (resetn),
        .miss_valid    (miss_valid),
        .miss_ready    (miss_ready),
        .miss_addr     (miss_addr),
        .flush_req     (flush_req),
        .flush_done    (flush_done),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req       (mem_req),
        .fifo_valid    (fifo_valid),
        .fifo_ready    (fifo_ready),
        .fifo_entry    (fifo_entry),
        .data_we       (data_we),
        .data_index    (data_index),
        .data_beat     (data_beat),
        .data_wdata    (data_wdata),
        .tag_we        (tag_we),
        .tag_index     (tag_index),
        .tag_wdata     (tag_wdata),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .resp_error    (resp_error),
        .fill_done     (fill_done),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] bd(input logic [15:0] s, input int idx);
        return {16'hC0DE, s, 32'(idx) * 32'h0101_0101 + 32'h10};
    endfunction

    // Expects the controller in FLUSH with flush_cnt = 0 at entry.
    task automatic check_walk(input int pulse_at);
        for (int i = 0; i < 128; i++) begin
            tick();
            flush_req = (i == pulse_at);
            chk("walk", {flush_done, tag_we, tag_index, tag_wdata}, {1'b0, 1'b1, 7'(i), 52'd0});
        end
        flush_req = 1'b0;
        tick();
        chk("flush_done", {flush_done, tag_we, miss_ready, busy}, 4'b1010);
        tick();
        chk("flush_done_pulse", {flush_done, busy, miss_ready}, 3'b001);
    endtask

    // Expects IDLE at entry; returns one cycle after DONE.
    task automatic run_miss(input logic [63:0] addr, input int n, input int err_idx,
                            input int hold, input logic [15:0] seed);
        logic [6:0]  set;
        logic [2:0]  crit;
        logic [50:0] tag;
        logic        err;
        imem_req_t   er;
        int          idx;
        set      = addr[12:6];
        crit     = addr[5:3];
        tag      = addr[63:13];
        er.addr  = CRIT ? {addr[63:3], 3'b000} : {addr[63:6], 6'b000000};
        er.len   = 8'd7;
        er.size  = 3'b011;
        er.burst = CRIT ? WRAP : INCR;
        err      = (n != 8);

        miss_valid = 1'b1;
        miss_addr  = addr;
        #1;
        chk("miss_ready", miss_ready, 1'b1);
        tick();
        miss_valid = 1'b0;
        chk("req", {mem_req_valid, mem_req}, {1'b1, er});
        for (int k = 0; k < hold; k++) begin
            tick();
            chk("req_hold", {mem_req_valid, fifo_ready, mem_req}, {1'b1, 1'b0, er});
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("req_done", {mem_req_valid, fifo_ready, busy}, 3'b011);

        for (int j = 0; j < n; j++) begin
            idx = CRIT ? (int'(crit) + j) % 8 : j;
            if (idx == err_idx) err = 1'b1;
            fifo_valid       = 1'b1;
            fifo_entry.error = (idx == err_idx);
            fifo_entry.last  = (j == n - 1);
            fifo_entry.data  = bd(seed, idx);
            tick();
            chk("beat", {data_we, data_index, data_beat, data_wdata},
                {1'b1, set, 3'(idx), bd(seed, idx)});
            chk("resp_flags", {resp_valid, resp_error, fill_done},
                {(CRIT && j == 0) || (!CRIT && j == n - 1),
                 CRIT ? (j == 0 && idx == err_idx) : (j == n - 1 && err),
                 j == n - 1});
        end
        fifo_valid = 1'b0;
        fifo_entry = '0;
        chk("tag", {tag_we, tag_index, tag_wdata}, {1'b1, set, ~err, tag});
        chk("resp_data", resp_data, bd(seed, int'(crit)));
        tick();
        chk("back_idle", {miss_ready, busy, tag_we, fill_done, resp_valid, data_we, mem_req_valid},
            7'b1000000);
    endtask

    initial begin
        resetn        = 1'b0;
        miss_valid    = 1'b0;
        miss_addr     = '0;
        flush_req     = 1'b0;
        mem_req_ready = 1'b0;
        fifo_valid    = 1'b0;
        fifo_entry    = '0;

        tick();
        tick();
        chk("reset_ctl", {miss_ready, flush_done, mem_req_valid, fifo_ready, data_we, tag_we,
                          resp_valid, resp_error, fill_done, busy}, 10'd0);
        chk("reset_data", {mem_req, tag_wdata, data_index, tag_index, data_beat}, '0);
        chk("reset_words", {data_wdata, resp_data}, '0);

        resetn = 1'b1;
        check_walk(-1);

        run_miss(64'h0000_0000_0000_2A58, 8, -1, 5, 16'h0001);
        run_miss(64'h0000_0000_0000_2A58, 8, 5, 0, 16'h0002);
        run_miss(64'h0000_0000_0000_2A58, 5, -1, 0, 16'h0003);
        run_miss(64'hFFFF_FFFF_FFFF_FFC0, 8, -1, 1, 16'h0004);

        miss_valid = 1'b1;
        flush_req  = 1'b1;
        miss_addr  = 64'h0000_0000_0000_1000;
        #1;
        chk("flush_prio_ready", miss_ready, 1'b0);
        tick();
        miss_valid = 1'b0;
        flush_req  = 1'b0;
        chk("flush_prio_state", {busy, mem_req_valid, miss_ready}, 3'b100);
        check_walk(50);

        run_miss(64'h0000_0000_0000_0C18, 8, 0, 0, 16'h0005);

        miss_valid = 1'b1;
        miss_addr  = 64'h0000_0000_0000_2A58;
        tick();
        miss_valid    = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        fifo_valid    = 1'b1;
        fifo_entry    = '{error: 1'b0, last: 1'b0, data: 64'h1234};
        tick();
        tick();
        resetn     = 1'b0;
        fifo_valid = 1'b0;
        #1;
        chk("midreset", {busy, data_we, fifo_ready, miss_ready, mem_req_valid, tag_we}, 6'd0);
        tick();
        resetn = 1'b1;
        check_walk(-1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_refill_ctrl.md
# icache_refill_ctrl

Sequences instruction-cache line refills and invalidation for the fetch unit. On a fetch miss it issues one burst read request, accepts the returned beats from the memory response FIFO, and writes them into the data array. It then commits the tag and reports the requested word to fetch. It also walks every set to clear valid bits, both after reset and on an explicit flush.

## Interface
Parameters:
- LINE_BEATS, 8: 64-bit beats per line (64 B line); must be a power of 2.
- INDEX_W, 7: set index width (128 sets, direct-mapped).
- TAG_W, 51: tag width (64 − INDEX_W − 6).

Ports (one clock `clk`; reset `resetn` is asynchronous and active-low):
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- miss_valid  in  1  fetch miss request.
- miss_ready  out  1  miss accepted this cycle.
- miss_addr  in  64  faulting fetch address.
- flush_req  in  1  request invalidate-all.
- flush_done  out  1  one-cycle pulse when the walk completes.
- mem_req_valid  out  1  burst request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req  out  imem_req_t  burst descriptor.
- fifo_valid  in  1  response beat available.
- fifo_ready  out  1  beat popped.
- fifo_entry  in  fifo_entry_t  {error, last, data}.
- data_we  out  1  data-array write.
- data_index  out  INDEX_W  data-array set.
- data_beat  out  log2(LINE_BEATS)  beat within the line.
- data_wdata  out  64  beat data.
- tag_we  out  1  tag-array write.
- tag_index  out  INDEX_W  tag-array set.
- tag_wdata  out  cache_tag_t  {valid, tag}.
- resp_valid  out  1  one-cycle pulse; requested word available.
- resp_data  out  64  requested word.
- resp_error  out  1  the requested word or the fill carried an error.
- fill_done  out  1  one-cycle pulse when the tag is committed.
- busy  out  1  controller not IDLE.

## Operation
- States: FLUSH, IDLE, REQ, FILL, DONE. Reset places the controller in FLUSH with flush_cnt = 0.
- Address split: tag = addr[63:13], index = addr[12:6], crit_beat = addr[5:3]. These are latched on acceptance.
- IDLE:
  - miss_ready = 1 when flush_req = 0.
  - flush_req → FLUSH. flush_req wins over a simultaneous miss_valid; that miss is not accepted.
  - miss handshake → REQ.
- FLUSH:
  - One tag write per cycle: tag_index = flush_cnt, tag_wdata = {0, 0}.
  - After index 2^INDEX_W−1 is written: flush_done pulses and the state goes to IDLE.
  - flush_req asserted during the walk is ignored.
- REQ:
  - mem_req_valid is held until mem_req_ready.
  - mem_req.len = LINE_BEATS−1, size = 3'b011, addr/burst set per Configuration.
  - mem_req is stable while valid. On handshake → FILL.
- FILL:
  - fifo_ready = 1.
  - Each popped beat: data_beat = beat_cnt, beat_cnt increments modulo LINE_BEATS, and the error flag is ORed into err_acc.
  - The beat whose index equals crit_beat is captured into resp_data.
  - A beat with last = 1 ends the fill → DONE.
  - If `last` arrives on a beat other than the LINE_BEATS-th, err_acc is set.
- DONE (one cycle):
  - tag_we with tag_wdata = {~err_acc, tag}.
  - fill_done pulses; resp_error = err_acc.
  - → IDLE.
- Reset mid-operation: state returns to FLUSH; partial data is discarded. The outstanding memory burst is drained by the memory side, not by this block.

## Timing
- Reset value of every output is 0, including miss_ready. busy = 1 from the first cycle after resetn deasserts, because the walk starts.
- Flush walk takes 2^INDEX_W cycles. flush_done pulses in the cycle after the last tag write.
- Miss accepted in cycle t: mem_req_valid rises at t+1.
- data_we is registered and asserts one cycle after each beat is popped.
- tag_we, fill_done and DONE occur one cycle after the last beat is popped. The earliest next miss_ready is the cycle after that.
- resp_valid has no backpressure; fetch must sample it during the pulse.

## Configuration
- `ICACHE_CRIT_WORD_FIRST_EN` defined:
  - mem_req.addr = {addr[63:3], 3'b0}, burst = 2'b10 (WRAP), and beat_cnt starts at crit_beat.
  - resp_valid pulses one cycle after the first beat is popped; resp_error is that beat's error flag only.
  - fill_done still pulses at tag commit.
- Not defined:
  - mem_req.addr = {addr[63:6], 6'b0}, burst = 2'b01 (INCR), and beat_cnt starts at 0.
  - resp_valid pulses together with fill_done; resp_error = err_acc.

## Structure
- The shared CPU package gains:
  - refill_state_t enum (FLUSH, IDLE, REQ, FILL, DONE);
  - burst_t enum (FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10);
  - constant ICACHE_LINE_BEATS.
- Existing package types imem_req_t, fifo_entry_t and cache_tag_t are reused unchanged.
- There are no sub-modules; the beat counter and flush counter are inline.

## Test plan
- Reset release → 128 consecutive tag_we with indices 0..127 and valid = 0 → flush_done → miss_ready = 1.
- Miss at 0x0000_0000_0000_2A58 with 8 clean beats, in-order last, macro off:
  - mem_req = {addr 0x2A40, len 7, size 3, burst INCR};
  - data_beat 0..7 written to index 0x29;
  - tag_wdata = {1, 0x1}; resp_data = beat 3.
- Same miss with the macro on:
  - addr 0x2A58, burst WRAP;
  - data_beat sequence 3, 4, 5, 6, 7, 0, 1, 2;
  - resp_valid one cycle after the first pop.
- Beat 5 carries error = 1 → all 8 beats drained, tag_wdata.valid = 0, resp_error = 1.
- last on beat 4 → DONE early, tag valid = 0, resp_error = 1.
- miss_valid and flush_req asserted together in IDLE → FLUSH entered, miss_ready stays 0. mem_req_ready held low 5 cycles → mem_req stable throughout.
